// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and the fetch sequencer state type.
// Latency: n/a. Backpressure: n/a.
package cpu_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;

   localparam logic [ADDR_W-1:0] RESET_PC  = '0;
   localparam logic [DATA_W-1:0] HALT_WORD = 16'hFFFF;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: advances past the issued address (optionally a load target), wraps mod 2^ADDR_W.
// Latency: 1 cycle from Advance to new Pc. Backpressure: holds whenever Advance is low.
module pc_reg
   import cpu_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Advance,
   input  logic              Load,
   input  logic [ADDR_W-1:0] Load_Pc,
   output logic [ADDR_W-1:0] Pc
);

   logic [ADDR_W-1:0] base;

   assign base = Load ? Load_Pc : Pc;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Pc <= RESET_PC;
      end else if (Advance) begin
         Pc <= base + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a registered ROM, hands words+PC to decode.
// Latency: word issued in cycle t is on Instr with Instr_Valid in t+1. Backpressure: Stall freezes fetch, Redirect overrides it.
module fetch_ctrl
   import cpu_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Stall,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] Redirect_Pc,
   output logic              Rom_En,
   output logic [ADDR_W-1:0] Rom_Addr,
   input  logic [DATA_W-1:0] Rom_Data,
   output logic [DATA_W-1:0] Instr,
   output logic [ADDR_W-1:0] Instr_Pc,
   output logic              Instr_Valid,
   output logic              Halted,
   output logic [CNT_W-1:0]  Fetch_Cnt
);

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic              halt_hit;
   logic              issue;
   logic [ADDR_W-1:0] pc;

   pc_reg u_pc_reg (
      .Clk     (Clk),
      .Rst     (Rst),
      .Advance (issue),
      .Load    (Redirect),
      .Load_Pc (Redirect_Pc),
      .Pc      (pc)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      halt_hit = 1'b0;
      issue    = 1'b0;
      case (state_q)
         RUN: begin
            // A HALT word is only consumed when decode actually takes it.
            halt_hit = Instr_Valid && (Rom_Data == HALT_WORD) && !Stall && !Redirect;
            issue    = Redirect || (!Stall && !halt_hit);
            if (halt_hit) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            issue = Redirect;
            if (Redirect) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign Rom_En   = issue && !Rst;
   assign Rom_Addr = Redirect ? Redirect_Pc : pc;
   assign Instr    = Rom_Data;
   assign Halted   = (state_q == HALTED);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Instr_Pc    <= '0;
         Instr_Valid <= 1'b0;
         Fetch_Cnt   <= '0;
      end else if (issue) begin
         Instr_Pc    <= Rom_Addr;
         Instr_Valid <= 1'b1;
         if (Fetch_Cnt != '1) begin
            Fetch_Cnt <= Fetch_Cnt + CNT_W'(1);
         end
      end else if (halt_hit) begin
         Instr_Valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: registered ROM model, directed scenarios, then randomized traffic.
module tb_fetch_ctrl;

   logic        Clk;
   logic        Rst;
   logic        Stall;
   logic        Redirect;
   logic [7:0]  Redirect_Pc;
   logic        Rom_En;
   logic [7:0]  Rom_Addr;
   logic [15:0] Rom_Data;
   logic [15:0] Instr;
   logic [7:0]  Instr_Pc;
   logic        Instr_Valid;
   logic        Halted;
   logic [15:0] Fetch_Cnt;

   int tests = 0;
   int fails = 0;

   logic [15:0] mem [256];

   // Reference state: what decode should currently see, plus the next sequential address.
   logic [7:0]  m_pc;
   logic [7:0]  m_ipc;
   logic        m_valid;
   logic        m_halted;
   logic [15:0] m_cnt;

   fetch_ctrl dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Stall       (Stall),
      .Redirect    (Redirect),
      .Redirect_Pc (Redirect_Pc),
      .Rom_En      (Rom_En),
      .Rom_Addr    (Rom_Addr),
      .Rom_Data    (Rom_Data),
      .Instr       (Instr),
      .Instr_Pc    (Instr_Pc),
      .Instr_Valid (Instr_Valid),
      .Halted      (Halted),
      .Fetch_Cnt   (Fetch_Cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) begin
      if (Rst)         Rom_Data <= 16'h0000;
      else if (Rom_En) Rom_Data <= mem[Rom_Addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 8'h00;
      m_ipc    = 8'h00;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_cnt    = 16'h0000;
   endtask

   // One clock cycle: apply inputs, check every output against the model, advance the model.
   task automatic cycle(input logic rst, input logic stall, input logic redir, input logic [7:0] rpc);
      logic       hh;
      logic       iss;
      logic [7:0] addr;
      @(negedge Clk);
      Rst         = rst;
      Stall       = stall;
      Redirect    = redir;
      Redirect_Pc = rpc;
      #1;
      hh   = !m_halted && m_valid && (mem[m_ipc] == 16'hFFFF) && !stall && !redir;
      iss  = redir || (!m_halted && !stall && !hh);
      addr = redir ? rpc : m_pc;
      chk("rom_en",      32'(Rom_En),      32'(iss && !rst));
      chk("rom_addr",    32'(Rom_Addr),    32'(addr));
      chk("instr_valid", 32'(Instr_Valid), 32'(m_valid));
      chk("instr_pc",    32'(Instr_Pc),    32'(m_ipc));
      chk("halted",      32'(Halted),      32'(m_halted));
      chk("fetch_cnt",   32'(Fetch_Cnt),   32'(m_cnt));
      if (m_valid) chk("instr", 32'(Instr), 32'(mem[m_ipc]));
      if (rst) begin
         model_reset();
      end else if (iss) begin
         m_ipc    = addr;
         m_pc     = addr + 8'd1;
         m_valid  = 1'b1;
         m_halted = 1'b0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (hh) begin
         m_halted = 1'b1;
         m_valid  = 1'b0;
      end
   endtask

   initial begin
      Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_Pc = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
      mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd12; mem[3] = 16'd13;
      mem[4] = 16'd14; mem[5] = 16'hFFFF;
      repeat (2) @(negedge Clk);
      model_reset();

      // Free run 0..2, stall while ROM[2] is presented, then run into HALT at 5.
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("halted_after_halt_word", 32'(m_halted), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Redirect out of HALTED, then redirect under stall.
      cycle(1'b0, 1'b0, 1'b1, 8'h10);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'h40);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Wrap across 8'hFF.
      cycle(1'b0, 1'b0, 1'b1, 8'hFD);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Reset mid-stream with Instr_Pc at 8'h22, then restart from RESET_PC.
      cycle(1'b0, 1'b0, 1'b1, 8'h20);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
      chk("instr_pc_before_rst", 32'(Instr_Pc), 32'h22);
      cycle(1'b1, 1'b1, 1'b1, 8'h33);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Stall in the first post-reset cycle.
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      repeat (2) cycle(1'b0, 1'b1, 1'b0, 8'h00);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00);

      // Randomized traffic over a ROM with HALT words sprinkled in; reload only under reset.
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      for (int n = 0; n < 600; n++) begin
         cycle(1'b0 + ($urandom_range(0, 99) < 2),
               1'b0 + ($urandom_range(0, 99) < 30),
               1'b0 + ($urandom_range(0, 99) < 10),
               8'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
